// File: rtl/uart_pkg.sv
// uart_pkg: shared widths, default bit period and FSM state types for the UART loader.
package uart_pkg;
    localparam int DATA_WID = 32;
    localparam int UART_CLKS_PER_BIT = 868;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    typedef enum logic [1:0] {L_HDR, L_DATA, L_WAIT, L_DONE} ld_state_t;
endpackage

// File: rtl/uart_rx.sv
// uart_rx: 2-flop synchronizer plus 8N1 bit FSM producing one-cycle byte and framing-error pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);
    localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);
    rx_state_t   state;
    logic [1:0]  sync;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        held;
    logic        rx_s;
    assign rx_s = sync[1];
    always_ff @(posedge clk) begin
        if (rst) begin
            sync       <= 2'b11;
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            held       <= 1'b0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync       <= {sync[0], rx};
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: if (!rx_s) begin
                    state <= START;
                    cnt   <= HALF;
                end
                START: if (cnt != 0) cnt <= cnt - 16'd1;
                    else if (rx_s) state <= IDLE;
                    else begin
                        state   <= DATA;
                        cnt     <= FULL;
                        bit_idx <= '0;
                    end
                DATA: if (cnt != 0) cnt <= cnt - 16'd1;
                    else begin
                        shreg   <= {rx_s, shreg[7:1]};
                        cnt     <= FULL;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end
                // After a bad stop bit, stay here until the line returns high
                STOP: if (cnt != 0) cnt <= cnt - 16'd1;
                    else if (rx_s) begin
                        state      <= IDLE;
                        held       <= 1'b0;
                        byte_valid <= !held;
                        rx_byte    <= shreg;
                    end else begin
                        frame_err <= !held;
                        held      <= 1'b1;
                    end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/uart_loader.sv
// uart_loader: parses a word-count header from UART bytes and streams little-endian words with
// byte addresses to memory port B, then raises uart_done after a fixed delay.
module uart_loader
    import uart_pkg::*;
#(
    parameter int               CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter logic [31:0]      ADDR_BASE    = 32'h0000_0000,
    parameter int               MAX_WORDS    = 16384,
    parameter int               DONE_DELAY   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx,
    output logic [DATA_WID-1:0] uart_data,
    output logic [DATA_WID-1:0] uart_addr,
    output logic                uart_done,
    output logic                word_valid,
    output logic                err
);
    ld_state_t   state;
    logic [7:0]  rx_byte;
    logic        byte_valid;
    logic        frame_err;
    logic [31:0] sr;
    logic [31:0] nxt;
    logic [31:0] n_words;
    logic [31:0] k;
    logic [31:0] wait_cnt;
    logic [1:0]  idx;
    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );
    assign nxt = {rx_byte, sr[31:8]};
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= L_HDR;
            sr         <= '0;
            n_words    <= '0;
            k          <= '0;
            wait_cnt   <= '0;
            idx        <= '0;
            uart_data  <= '0;
            uart_addr  <= ADDR_BASE;
            uart_done  <= 1'b0;
            word_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (frame_err && state != L_DONE) err <= 1'b1;
            case (state)
                L_HDR: if (byte_valid) begin
                    sr  <= nxt;
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        // Empty image: header byte valid already counts as the first delay cycle
                        if (nxt == 0) begin
                            state    <= L_WAIT;
                            wait_cnt <= 32'd1;
                        end else if (nxt > 32'(MAX_WORDS)) begin
                            err <= 1'b1;
                            idx <= '0;
                        end else begin
                            n_words <= nxt;
                            k       <= '0;
                            state   <= L_DATA;
                        end
                    end
                end
                L_DATA: if (byte_valid) begin
                    sr  <= nxt;
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        uart_data  <= nxt;
                        uart_addr  <= ADDR_BASE + (k << 2);
                        word_valid <= 1'b1;
                        k          <= k + 32'd1;
                        if (k + 32'd1 == n_words) begin
                            state    <= L_WAIT;
                            wait_cnt <= '0;
                        end
                    end
                end
                L_WAIT: if (wait_cnt >= 32'(DONE_DELAY)) begin
                    state     <= L_DONE;
                    uart_done <= 1'b1;
                end else wait_cnt <= wait_cnt + 32'd1;
                default: ;
            endcase
        end
    end
endmodule
